// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stall-vector layout, NOP payload constants
// and the enums used by the pipeline stage register.
package pipe_stage_reg_pkg;

   localparam int STALL_W = 6;

   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   localparam logic [7:0]  EX_NOP_OP  = 8'h00;
   localparam logic [2:0]  EX_RES_NOP = 3'b000;
   localparam logic [31:0] ZeroWord   = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr = 5'b00000;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_t;

   typedef enum logic [1:0] {
      ACT_FLUSH  = 2'd0,
      ACT_BUBBLE = 2'd1,
      ACT_LOAD   = 2'd2,
      ACT_HOLD   = 2'd3
   } stage_act_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// One inter-stage pipeline register with flush/bubble/load/hold control,
// plus bubble, flush and stuck-hold statistics.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int                DATA_W     = 140,
   parameter int                STAGE      = 2,
   parameter logic [DATA_W-1:0] NOP_VALUE  = '0,
   parameter int                CNT_W      = 16,
   parameter int                HOLD_LIMIT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               stuck,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   flush_cnt,
   output logic [7:0]         hold_cnt
);

   // A limit outside the 8-bit hold counter range can never be reached.
   localparam bit         STUCK_EN = (HOLD_LIMIT >= 1) && (HOLD_LIMIT <= 255);
   localparam logic [7:0] STUCK_AT = 8'(HOLD_LIMIT - 1);

   stage_act_t        act;
   stage_state_t      state_q, state_d;
   logic [DATA_W-1:0] data_p1;
   logic              bubble_inc, flush_inc, hold_inc, hold_clr;
   logic              stall_unused;

   assign stall_unused = ^stall;

   always_comb begin
      act = ACT_HOLD;
      if (flush) begin
         act = ACT_FLUSH;
      end else if (!stall[STAGE]) begin
         act = ACT_LOAD;
      end else if (!stall[STAGE+1]) begin
         act = ACT_BUBBLE;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (act)
         ACT_FLUSH, ACT_BUBBLE: state_d = ST_EMPTY;
         ACT_LOAD:              state_d = in_valid ? ST_FULL : ST_EMPTY;
         ACT_HOLD:              state_d = state_q;
         default:               state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Stage boundary p0 -> p1: payload register
   always_ff @(posedge clk) begin
      if (rst) begin
         data_p1 <= NOP_VALUE;
      end else begin
         unique case (act)
            ACT_FLUSH, ACT_BUBBLE: data_p1 <= NOP_VALUE;
            ACT_LOAD:              data_p1 <= in_valid ? in_data : NOP_VALUE;
            ACT_HOLD:              data_p1 <= data_p1;
            default:               data_p1 <= data_p1;
         endcase
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_p1;

   assign bubble_inc = (act == ACT_BUBBLE);
   assign flush_inc  = (act == ACT_FLUSH) && (state_q == ST_FULL);
   assign hold_inc   = (act == ACT_HOLD) && (state_q == ST_FULL);
   assign hold_clr   = (act != ACT_HOLD);

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bubble_inc),
      .clr   (1'b0),
      .count (bubble_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .clr   (1'b0),
      .count (flush_cnt)
   );

   sat_counter #(.W(8)) u_hold_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hold_inc),
      .clr   (hold_clr),
      .count (hold_cnt)
   );

   // Pulses only on the step into the limit, so a saturated run cannot re-fire.
   always_ff @(posedge clk) begin
      if (rst) begin
         stuck <= 1'b0;
      end else begin
         stuck <= STUCK_EN && hold_inc && (hold_cnt == STUCK_AT);
      end
   end

endmodule
